// File: rtl/fetch_redirect_arbiter.sv
// fetch_redirect_arbiter
//   Collects PC-redirect requests from four sources and serialises them onto the
//   fetch PC. Priority, highest first: flush (0), mispredict (1), invalid
//   instruction (2), return (3).
//   A single pending slot holds the winning redirect while the icache is stalled.
//   The slot is issued in any cycle where cache_ready is high. Every issued
//   redirect advances the fetch epoch, which squashes in-flight packets.
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   *_valid / *_pc            redirect requests from the four sources
//   cache_ready               icache accepts a new fetch PC this cycle
//   redir_valid_o/_pc_o/_src_o redirect issued this cycle (combinational on cache_ready)
//   kill_o                    a redirect is pending; mask fetch output valid
//   epoch_o                   current fetch epoch (wraps)
//   redir_cnt_o, drop_cnt_o   saturating statistics
module fetch_redirect_arbiter #(
  parameter int PC_BITS    = 32,
  parameter int EPOCH_BITS = 3,
  parameter int CNT_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_valid,
  input  logic [PC_BITS-1:0]    flush_pc,
  input  logic                  mispred_valid,
  input  logic [PC_BITS-1:0]    mispred_pc,
  input  logic                  invinstr_valid,
  input  logic [PC_BITS-1:0]    invinstr_pc,
  input  logic                  ret_valid,
  input  logic [PC_BITS-1:0]    ret_pc,
  input  logic                  cache_ready,
  output logic                  redir_valid_o,
  output logic [PC_BITS-1:0]    redir_pc_o,
  output logic [1:0]            redir_src_o,
  output logic                  kill_o,
  output logic [EPOCH_BITS-1:0] epoch_o,
  output logic [CNT_BITS-1:0]   redir_cnt_o,
  output logic [CNT_BITS-1:0]   drop_cnt_o
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    sat_inc = (v == {CNT_BITS{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_t               state, state_nxt;
  logic [PC_BITS-1:0]   pend_pc, pend_pc_nxt;
  logic [1:0]           pend_src, pend_src_nxt;
  logic [EPOCH_BITS-1:0] epoch;
  logic [CNT_BITS-1:0]  redir_cnt, drop_cnt;

  logic                 best_valid;
  logic [PC_BITS-1:0]   best_pc;
  logic [1:0]           best_src;
  logic                 issue;
  logic                 drop_inc;

  // Same-cycle selection: lowest-numbered valid source wins
  always_comb begin
    best_valid = flush_valid | mispred_valid | invinstr_valid | ret_valid;
    best_pc    = ret_pc;
    best_src   = 2'd3;
    if (flush_valid) begin
      best_pc  = flush_pc;
      best_src = 2'd0;
    end else if (mispred_valid) begin
      best_pc  = mispred_pc;
      best_src = 2'd1;
    end else if (invinstr_valid) begin
      best_pc  = invinstr_pc;
      best_src = 2'd2;
    end
  end

  assign issue = (state == HOLD) & cache_ready;

  // Next-state and slot update
  always_comb begin
    state_nxt    = state;
    pend_pc_nxt  = pend_pc;
    pend_src_nxt = pend_src;
    drop_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (best_valid) begin
          state_nxt    = HOLD;
          pend_pc_nxt  = best_pc;
          pend_src_nxt = best_src;
        end
      end
      HOLD: begin
        if (cache_ready) begin
          if (best_valid) begin
            pend_pc_nxt  = best_pc;
            pend_src_nxt = best_src;
          end else begin
            state_nxt = IDLE;
          end
        end else if (best_valid) begin
          // Stalled: the new request either overwrites the slot or is ignored;
          // one of the two is lost either way, so it always counts as a drop.
          // An equal source is the newer request and replaces the old one.
          drop_inc = 1'b1;
          if (best_src <= pend_src) begin
            pend_pc_nxt  = best_pc;
            pend_src_nxt = best_src;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend_pc   <= '0;
      pend_src  <= '0;
      epoch     <= '0;
      redir_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      pend_pc  <= pend_pc_nxt;
      pend_src <= pend_src_nxt;
      if (issue) begin
        epoch     <= epoch + 1'b1;
        redir_cnt <= sat_inc(redir_cnt);
      end
      if (drop_inc) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  assign kill_o        = (state == HOLD);
  assign redir_valid_o = issue;
  assign redir_pc_o    = pend_pc;
  assign redir_src_o   = pend_src;
  assign epoch_o       = epoch;
  assign redir_cnt_o   = redir_cnt;
  assign drop_cnt_o    = drop_cnt;

endmodule
